// File: rtl/ahb_arbiter_if.sv
// Arbitration signals between the AHB masters, the bus mux and the arbiter.
// The master modport is the arbiter side; slave is the requester/bus side.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
) ();
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic                   HREADY;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [1:0]             HMASTER;
    logic                   HMASTLOCK;

    modport master (
        input  HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
        output HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        output HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
        input  HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter for up to four masters with burst and lock
// hold-off, switching only on accepted transfers and parking when idle.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic          HCLK,
    input  logic          HRESET,
    ahb_arbiter_if.master bus
);

    localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic [3:0]             cnt_q, cnt_d;
    logic [1:0]             last_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [1:0]             master_q;
    logic                   mlock_q;

    logic [3:0] req4;
    logic [3:0] lock4;
    logic       open_arb;
    logic       found;
    logic [1:0] win;
    logic [1:0] scan_idx;

    assign req4  = 4'(bus.HBUSREQ);
    assign lock4 = 4'(bus.HLOCK);

    always_comb begin
        cnt_d = cnt_q;
        case (bus.HTRANS)
            T_IDLE: cnt_d = 4'd0;
            T_BUSY: cnt_d = cnt_q;
            T_NONSEQ: begin
                case (bus.HBURST)
                    3'b010, 3'b011: cnt_d = 4'd3;
                    3'b100, 3'b101: cnt_d = 4'd7;
                    3'b110, 3'b111: cnt_d = 4'd15;
                    default:        cnt_d = 4'd0;
                endcase
            end
            default: cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        endcase
    end

    assign open_arb = (cnt_d == 4'd0) && !lock4[last_q];

    // Scan starts just after the current owner and ends on the owner itself.
    always_comb begin
        win      = DEF_IDX;
        found    = 1'b0;
        scan_idx = 2'd0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            scan_idx = 2'((int'(last_q) + off) % NUM_MASTERS);
            if (!found && req4[scan_idx]) begin
                win   = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt_q    <= 4'd0;
            last_q   <= DEF_IDX;
            grant_q  <= ONE << DEF_IDX;
            master_q <= DEF_IDX;
            mlock_q  <= 1'b0;
        end else if (bus.HREADY) begin
            cnt_q    <= cnt_d;
            master_q <= last_q;
            mlock_q  <= lock4[last_q];
            if (open_arb) begin
                grant_q <= ONE << win;
                last_q  <= win;
            end
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed-vector bench for ahb_arbiter: round robin, bursts, waits,
// locked sequences, early burst termination and asynchronous reset.
module tb_ahb_arbiter;

    logic HCLK;
    logic HRESET;
    int   checks;
    int   errors;

    ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

    ahb_arbiter #(
        .NUM_MASTERS(4),
        .DEFAULT_MASTER(0)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                         input logic rdy, input logic [1:0] tr,
                         input logic [2:0] bu);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HREADY  = rdy;
        bus.HTRANS  = tr;
        bus.HBURST  = bu;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g,
                           input logic [1:0] m, input logic l);
        chk({tag, ".grant"}, 32'(bus.HGRANT), 32'(g));
        chk({tag, ".master"}, 32'(bus.HMASTER), 32'(m));
        chk({tag, ".mlock"}, 32'(bus.HMASTLOCK), 32'(l));
    endtask

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    initial begin
        checks = 0;
        errors = 0;
        HRESET = 1'b1;
        drive(4'b0000, 4'b0000, 1'b1, IDLE, 3'b000);
        #1;
        chk_out("rst", 4'b0001, 2'd0, 1'b0);
        tick();
        HRESET = 1'b0;
        tick();
        chk_out("park", 4'b0001, 2'd0, 1'b0);

        // round robin among 1..3, SINGLE every cycle
        drive(4'b1110, 4'b0000, 1'b1, NSEQ, 3'b000);
        tick(); chk_out("rr1", 4'b0010, 2'd0, 1'b0);
        tick(); chk_out("rr2", 4'b0100, 2'd1, 1'b0);
        tick(); chk_out("rr3", 4'b1000, 2'd2, 1'b0);
        tick(); chk_out("rr4", 4'b0010, 2'd3, 1'b0);

        // asynchronous reset between edges
        #1 HRESET = 1'b1;
        #1 chk_out("arst", 4'b0001, 2'd0, 1'b0);
        drive(4'b0010, 4'b0000, 1'b1, IDLE, 3'b000);
        #1 HRESET = 1'b0;

        // master 1 takes bus, then INCR4 with master 2 requesting
        tick(); chk_out("m1g", 4'b0010, 2'd0, 1'b0);
        tick(); chk_out("m1own", 4'b0010, 2'd1, 1'b0);
        drive(4'b0110, 4'b0000, 1'b1, NSEQ, 3'b011);
        tick(); chk_out("i4b1", 4'b0010, 2'd1, 1'b0);
        bus.HTRANS = SEQ;
        tick(); chk_out("i4b2", 4'b0010, 2'd1, 1'b0);
        tick(); chk_out("i4b3", 4'b0010, 2'd1, 1'b0);
        tick(); chk_out("i4b4", 4'b0100, 2'd1, 1'b0);
        drive(4'b0100, 4'b0000, 1'b1, IDLE, 3'b000);
        tick(); chk_out("i4ho", 4'b0100, 2'd2, 1'b0);

        // master 2 INCR4 with two wait states on beat 2, master 3 waiting
        drive(4'b1100, 4'b0000, 1'b1, NSEQ, 3'b011);
        tick(); chk_out("w1", 4'b0100, 2'd2, 1'b0);
        bus.HTRANS = SEQ;
        bus.HREADY = 1'b0;
        tick(); chk_out("w2", 4'b0100, 2'd2, 1'b0);
        tick(); chk_out("w3", 4'b0100, 2'd2, 1'b0);
        bus.HREADY = 1'b1;
        tick(); chk_out("w4", 4'b0100, 2'd2, 1'b0);
        tick(); chk_out("w5", 4'b0100, 2'd2, 1'b0);
        tick(); chk_out("w6", 4'b1000, 2'd2, 1'b0);
        drive(4'b1000, 4'b0000, 1'b0, IDLE, 3'b000);
        tick(); chk_out("w7", 4'b1000, 2'd2, 1'b0);
        bus.HREADY = 1'b1;
        tick(); chk_out("w8", 4'b1000, 2'd3, 1'b0);

        // master 3 locked while everyone requests
        drive(4'b1111, 4'b1000, 1'b1, NSEQ, 3'b000);
        tick(); chk_out("lk1", 4'b1000, 2'd3, 1'b1);
        tick(); chk_out("lk2", 4'b1000, 2'd3, 1'b1);
        bus.HLOCK = 4'b0000;
        tick(); chk_out("lk3", 4'b0001, 2'd3, 1'b0);
        tick(); chk_out("lk4", 4'b0010, 2'd0, 1'b0);

        // master 2 INCR8 cut short by IDLE, master 0 requesting
        drive(4'b0100, 4'b0000, 1'b1, IDLE, 3'b000);
        tick(); chk_out("i8g", 4'b0100, 2'd1, 1'b0);
        tick(); chk_out("i8own", 4'b0100, 2'd2, 1'b0);
        drive(4'b0001, 4'b0000, 1'b1, NSEQ, 3'b101);
        tick(); chk_out("i8b1", 4'b0100, 2'd2, 1'b0);
        bus.HTRANS = SEQ;
        tick(); chk_out("i8b2", 4'b0100, 2'd2, 1'b0);
        tick(); chk_out("i8b3", 4'b0100, 2'd2, 1'b0);
        bus.HTRANS = IDLE;
        tick(); chk_out("i8idle", 4'b0001, 2'd2, 1'b0);
        tick(); chk_out("i8new", 4'b0001, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter that shares the AHB address/data bus between up to four masters in front of the AHB slave.
- Drives one-hot `HGRANT` and encoded `HMASTER`; the external address/control/write-data mux uses `HMASTER` to select the owning master.
- Keeps ownership stable across fixed-length bursts and locked sequences.
- Switches only on `HREADY`-high boundaries.
- Parks the bus on a default master when nobody requests.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesters, legal range 2..4.
- `DEFAULT_MASTER`, 0: park master index, must be < `NUM_MASTERS`.

Ports:
- `HCLK`  in  1  bus clock. One clock; all state updates on rising edge.
- `HRESET`  in  1  reset, asynchronous, active-high.
- `HBUSREQ`  in  NUM_MASTERS  per-master bus request.
- `HLOCK`  in  NUM_MASTERS  per-master locked-transfer request.
- `HREADY`  in  1  transfer-accepted from the selected slave.
- `HTRANS`  in  2  transfer type of the current owner, after the mux: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HBURST`  in  3  burst type of the current owner: 000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16.
- `HGRANT`  out  NUM_MASTERS  one-hot grant (next address-phase owner), registered.
- `HMASTER`  out  2  index of current address-phase owner, registered.
- `HMASTLOCK`  out  1  current owner is performing a locked sequence, registered.

## Operation
- Internal state:
  - `beat_cnt`, 4 bits: fixed-burst beats remaining.
  - `last_idx`, 2 bits: round-robin pointer, equal to the index of the current `HGRANT`.
- An accepted transfer is a rising edge with `HREADY`=1. All registers below update only on accepted edges; with `HREADY`=0 everything holds.
- Burst counter, evaluated at accepted edges:
  - `HTRANS`=NONSEQ with a fixed burst: `beat_cnt` <= beats-1, i.e. 3, 7 or 15.
  - `HTRANS`=NONSEQ with SINGLE/INCR: `beat_cnt` <= 0.
  - `HTRANS`=SEQ with `beat_cnt`>0: `beat_cnt` <= `beat_cnt`-1.
  - `HTRANS`=IDLE: `beat_cnt` <= 0 (early burst termination).
  - `HTRANS`=BUSY: `beat_cnt` holds.
- `next_cnt` is the value `beat_cnt` would take at the current edge.
- Arbitration is open at an accepted edge when both hold:
  - `next_cnt`==0;
  - `HLOCK[last_idx]`==0.

  Otherwise it is closed and `HGRANT` holds.
- Winner selection when open:
  - Scan indices `last_idx`+1, +2, … wrapping modulo `NUM_MASTERS`, ending with `last_idx` itself. The first index with `HBUSREQ` set wins.
  - If no request is set, the winner is `DEFAULT_MASTER` (park).
  - Indices ≥ `NUM_MASTERS` are never granted. Their request bits do not exist.
- On an open accepted edge, `HGRANT` <= onehot(winner) and `last_idx` <= winner.
- On every accepted edge, `HMASTER` <= index of the current `HGRANT` (value before this edge's update) and `HMASTLOCK` <= `HLOCK`[that index].
- State summary:
  - FREE: `beat_cnt`=0, unlocked.
  - BURST: `beat_cnt`>0.
  - LOCKED: `HLOCK` of granted master high; overrides FREE.
  - Transitions between them follow the counter and lock rules above.

## Timing
- Reset values (asynchronous, while `HRESET`=1):
  - `HGRANT` = onehot(`DEFAULT_MASTER`);
  - `HMASTER` = `DEFAULT_MASTER`;
  - `HMASTLOCK` = 0;
  - `beat_cnt` = 0;
  - `last_idx` = `DEFAULT_MASTER`.
- Reset mid-burst abandons the burst. The first accepted edge after release arbitrates normally.
- Request-to-grant latency: 1 accepted edge from `HBUSREQ` high (if open). Grant-to-ownership: `HMASTER` follows `HGRANT` one further accepted edge later.
- Burst handover:
  - Arbitration reopens on the edge accepting the last burst address, e.g. the 4th beat of INCR4.
  - The old owner keeps address ownership for one handover cycle and must drive IDLE there.
  - The new owner drives NONSEQ in the following cycle.
- `HREADY` low during any of the above stretches every step by the wait cycles; no grant or `HMASTER` change occurs in a wait cycle.
- Simultaneous events:
  - A request arriving on the same edge a burst's last beat is accepted is considered in that arbitration.
  - The current owner re-requesting with no other requester keeps the grant.
- Lock release: the first accepted edge where the owner's `HLOCK` is 0 and `next_cnt`==0 arbitrates. `HMASTLOCK` drops on that same edge.

## Test plan
- Reset, no requests, `HREADY`=1, `HTRANS`=IDLE → `HGRANT`=0001, `HMASTER`=0, `HMASTLOCK`=0; assert `HRESET` mid-stream → outputs return to these values without a clock edge.
- `HBUSREQ`=1110 held, SINGLE NONSEQ transfers every cycle → `HGRANT` sequence 0010, 0100, 1000, 0010; `HMASTER` lags by one cycle.
- Master 1 owns the bus and issues INCR4 (NONSEQ + 3 SEQ) while master 2 requests → `HGRANT` stays 0010 until the 4th beat is accepted, then 0100; `HMASTER`=2 one edge later.
- Same INCR4, `HREADY`=0 for 2 cycles on beat 2 → grant switch delayed exactly 2 cycles; `beat_cnt` holds during the waits.
- Master 3 with `HLOCK`=1 and SINGLE transfers while masters 0–2 request → `HGRANT`=1000 and `HMASTLOCK`=1 for the whole lock; `HLOCK` drops → next accepted edge grants 0001, `HMASTLOCK`=0.
- INCR8 terminated by IDLE after 3 beats, with master 0 requesting → arbitration opens on the IDLE edge and `HGRANT`=0001 on that edge.
